// File: rtl/stepped_ram_ctrl.sv
// Single-port RAM with manual / step-pointer addressing and a whole-array fill engine.
// Latency: read data registered, 1 cycle (write-first); fill takes exactly DEPTH cycles then a one-cycle DONE.
// Backpressure: none; while busy, all access inputs are ignored and dout holds.
module stepped_ram_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic              step,
    input  logic              step_mode,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] din,
    input  logic              fill_start,
    input  logic              fill_incr,
    output logic [DATA_W-1:0] dout,
    output logic [ADDR_W-1:0] ptr,
    output logic              busy,
    output logic              done
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic              incr_q, incr_d;
    logic              step_q, step_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] fill_data;
    logic              step_rise;

    assign ea        = step_mode ? ptr_q : address;
    assign step_d    = step;
    assign step_rise = step & ~step_q;
    // Index is zero-extended into the data width; sum wraps at DATA_W bits.
    assign fill_data = incr_q ? (seed_q + DATA_W'(idx_q)) : seed_q;

    // Next-state, pointer, read data and RAM write port selection.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        dout_d    = dout_q;
        seed_d    = seed_q;
        incr_d    = incr_q;
        mem_we    = 1'b0;
        mem_addr  = ea;
        mem_wdata = din;
        case (state_q)
            ST_IDLE: begin
                if (fill_start) begin
                    // Fill request wins over write/step; this cycle only reads.
                    seed_d  = din;
                    incr_d  = fill_incr;
                    idx_d   = '0;
                    state_d = ST_FILL;
                    dout_d  = mem[ea];
                end else begin
                    if (write) begin
                        mem_we = 1'b1;
                        dout_d = din;
                    end else begin
                        dout_d = mem[ea];
                    end
                    // Write above uses the old ptr; the increment lands at the same edge.
                    if (step_mode && step_rise) begin
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
                end
            end
            ST_FILL: begin
                mem_we    = 1'b1;
                mem_addr  = idx_q;
                mem_wdata = fill_data;
                if (&idx_q) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            ST_DONE: begin
                ptr_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state and output registers; reset aborts any fill at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            dout_q  <= '0;
            seed_q  <= '0;
            incr_q  <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            dout_q  <= dout_d;
            seed_q  <= seed_d;
            incr_q  <= incr_d;
            step_q  <= step_d;
        end
    end

    // RAM array write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    assign dout = dout_q;
    assign ptr  = ptr_q;
    assign busy = (state_q == ST_FILL);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_stepped_ram_ctrl.sv
module tb_stepped_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        write = 1'b0;
    logic        step = 1'b0;
    logic        step_mode = 1'b0;
    logic [5:0]  address = '0;
    logic [15:0] din = '0;
    logic        fill_start = 1'b0;
    logic        fill_incr = 1'b0;
    logic [15:0] dout;
    logic [5:0]  ptr;
    logic        busy;
    logic        done;

    int n_pass = 0;
    int n_total = 0;
    bit cmp_en = 1'b0;

    stepped_ram_ctrl #(.DATA_W(16), .ADDR_W(6)) dut (
        .clk        (clk),
        .reset      (rst),
        .write      (write),
        .step       (step),
        .step_mode  (step_mode),
        .address    (address),
        .din        (din),
        .fill_start (fill_start),
        .fill_incr  (fill_incr),
        .dout       (dout),
        .ptr        (ptr),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Fill is modelled as "writes remaining"; DONE as a pending one-cycle flag.
    logic [15:0] m_mem [64];
    bit          m_known [64];
    int          m_left = 0;
    bit          m_done = 1'b0;
    logic [5:0]  m_ptr = '0;
    logic [15:0] m_dout = '0;
    bit          m_dknown = 1'b1;
    logic        m_sprev = 1'b0;
    logic [15:0] m_seed = '0;
    bit          m_incr = 1'b0;

    always @(posedge clk or posedge rst) begin : mdl
        logic       rise;
        int         k;
        logic [5:0] ea;
        if (rst) begin
            m_left = 0; m_done = 1'b0; m_ptr = '0; m_dout = '0;
            m_dknown = 1'b1; m_sprev = 1'b0;
        end else begin
            rise = step & ~m_sprev;
            m_sprev = step;
            ea = step_mode ? m_ptr : address;
            if (m_done) begin
                m_done = 1'b0;
                m_ptr = '0;
            end else if (m_left > 0) begin
                k = 64 - m_left;
                m_mem[k] = m_incr ? (m_seed + 16'(k)) : m_seed;
                m_known[k] = 1'b1;
                m_left--;
                if (m_left == 0) m_done = 1'b1;
            end else if (fill_start) begin
                m_seed = din;
                m_incr = fill_incr;
                m_left = 64;
                m_dout = m_mem[ea];
                m_dknown = m_known[ea];
            end else begin
                if (write) begin
                    m_mem[ea] = din;
                    m_known[ea] = 1'b1;
                    m_dout = din;
                    m_dknown = 1'b1;
                end else begin
                    m_dout = m_mem[ea];
                    m_dknown = m_known[ea];
                end
                if (step_mode && rise) m_ptr = m_ptr + 6'd1;
            end
        end
    end

    // Cycle-by-cycle comparison of DUT against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("ptr", {26'd0, ptr}, {26'd0, m_ptr});
            check("busy", {31'd0, busy}, {31'd0, m_left > 0});
            check("done", {31'd0, done}, {31'd0, m_done});
            if (m_dknown) check("dout", {16'd0, dout}, {16'd0, m_dout});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [15:0] d);
        step_mode = 1'b0; address = a; din = d; write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [5:0] a, input logic [15:0] exp);
        step_mode = 1'b0; write = 1'b0; address = a;
        tick();
        check(name, {16'd0, dout}, {16'd0, exp});
    endtask

    task automatic wait_fill();
        for (int n = 0; n < 200 && (busy || done); n++) tick();
        check("fill_ends", {30'd0, busy, done}, 32'd0);
    endtask

    task automatic start_fill(input logic [15:0] seed, input logic inc);
        write = 1'b0; din = seed; fill_incr = inc; fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
    endtask

    initial begin
        int bc;
        int dc;
        repeat (3) tick();
        check("rst_dout", {16'd0, dout}, 32'd0);
        check("rst_ptr", {26'd0, ptr}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        cmp_en = 1'b1;

        // Manual access
        wr(6'd6, 16'h6666);
        wr(6'd5, 16'hA5A5);
        check("wr_first", {16'd0, dout}, 32'h0000A5A5);
        rd_chk("rd5", 6'd5, 16'hA5A5);
        rd_chk("rd6", 6'd6, 16'h6666);

        // Step walk: each pulse held 4 cycles counts once
        step_mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step = 1'b1; repeat (4) tick();
            step = 1'b0; repeat (2) tick();
        end
        check("ptr3", {26'd0, ptr}, 32'd3);
        din = 16'h1234; write = 1'b1; tick(); write = 1'b0;
        check("step_wr", {16'd0, dout}, 32'h00001234);
        tick();
        check("step_rd", {16'd0, dout}, 32'h00001234);
        check("ptr3_hold", {26'd0, ptr}, 32'd3);

        // Walk to 63, then write and step together
        for (int i = 0; i < 60; i++) begin
            step = 1'b1; tick(); step = 1'b0; tick();
        end
        check("ptr63", {26'd0, ptr}, 32'd63);
        din = 16'hBEEF; write = 1'b1; step = 1'b1;
        tick();
        write = 1'b0; step = 1'b0;
        check("wrap_ptr", {26'd0, ptr}, 32'd0);
        check("wrap_wr", {16'd0, dout}, 32'h0000BEEF);
        rd_chk("rd63", 6'd63, 16'hBEEF);

        // Incrementing fill
        start_fill(16'hFFF0, 1'b1);
        bc = 0; dc = 0;
        repeat (80) begin
            if (busy) bc++;
            if (done) dc++;
            tick();
        end
        check("busy_len", bc, 32'd64);
        check("done_cnt", dc, 32'd1);
        check("fill_ptr", {26'd0, ptr}, 32'd0);
        rd_chk("inc0", 6'd0, 16'hFFF0);
        rd_chk("inc15", 6'd15, 16'hFFFF);
        rd_chk("inc16", 6'd16, 16'h0000);
        rd_chk("inc63", 6'd63, 16'h002F);

        // Constant fill of zero over 0xFFFF with noise on the ignored inputs
        start_fill(16'hFFFF, 1'b0);
        wait_fill();
        step_mode = 1'b1;
        start_fill(16'h0000, 1'b0);
        for (int i = 0; i < 50; i++) begin
            write = 1'($urandom); step = 1'($urandom);
            address = 6'($urandom); din = 16'($urandom);
            tick();
        end
        write = 1'b0; step = 1'b1;
        wait_fill();
        repeat (3) tick();
        check("noise_ptr", {26'd0, ptr}, 32'd0);
        step = 1'b0;
        for (int a = 0; a < 64; a++) rd_chk("zero_fill", 6'(a), 16'h0000);

        // Reset ten cycles into a fill
        start_fill(16'hFFFF, 1'b0);
        wait_fill();
        start_fill(16'h5555, 1'b0);
        repeat (10) tick();
        rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_dout", {16'd0, dout}, 32'd0);
        tick();
        rst = 1'b0;
        for (int a = 0; a < 64; a++)
            rd_chk("abort_mem", 6'(a), (a < 10) ? 16'h5555 : 16'hFFFF);
        start_fill(16'h0100, 1'b1);
        check("refill_busy", {31'd0, busy}, 32'd1);
        wait_fill();
        rd_chk("refill2", 6'd2, 16'h0102);
        rd_chk("refill63", 6'd63, 16'h013F);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
